pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline stall/flush controller for the in-order MIRI core. It generalises the former stage-enable/NOP-inject logic to N pipeline registers and adds load-use interlock, multi-cycle MUL occupancy, taken-branch flush and per-cause stall counters. The block sits beside decode and drives the enable and bubble inputs of every inter-stage register.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the MIRI pipeline hazard controller: register indices,
// NOP encoding, opcode values and the stall-cause enumeration.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_FD = 0;
  localparam int REG_DE = 1;
  localparam int REG_EM = 2;
  localparam int REG_MW = 3;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  localparam logic [7:0] OP_LDB  = 8'h10;
  localparam logic [7:0] OP_LDW  = 8'h11;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_BEQ  = 8'h30;
  localparam logic [7:0] OP_JUMP = 8'h31;

  // Listed in decreasing priority after CAUSE_NONE.
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_DCACHE   = 3'd1,
    CAUSE_MUL      = 3'd2,
    CAUSE_LOAD_USE = 3'd3,
    CAUSE_BRANCH   = 3'd4,
    CAUSE_ICACHE   = 3'd5
  } stall_cause_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the in-order MIRI pipeline: drives per-register
// load enables and NOP-inject bubbles, tracks MUL occupancy, counts stall cycles.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_W      = 5,
  parameter int MUL_LAT    = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_miss,
  input  logic                  dcache_miss,
  input  logic [REG_W-1:0]      id_src1,
  input  logic [REG_W-1:0]      id_src2,
  input  logic                  id_uses_src2,
  input  logic                  ex_is_load,
  input  logic [REG_W-1:0]      ex_dst,
  input  logic                  ex_is_mul,
  input  logic                  ex_branch_taken,
  output logic [NUM_STAGES-2:0] en_reg,
  output logic [NUM_STAGES-2:0] bubble,
  output logic                  wb_kill,
  output logic [CNT_W-1:0]      stall_d,
  output logic [CNT_W-1:0]      stall_i,
  output logic [CNT_W-1:0]      stall_hz
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  localparam int              MCNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MCNT_W-1:0] MUL_RELOAD = MCNT_W'(MUL_LAT - 1);

  logic [0:0]        state_q, state_d;
  logic [MCNT_W-1:0] mul_cnt_q, mul_cnt_d;

  logic         mul_issue;
  logic         mul_active;
  logic         load_use;
  stall_cause_e cause;

  assign mul_issue  = (state_q == ST_RUN) && ex_is_mul && (MUL_LAT > 1);
  assign mul_active = (state_q == ST_MUL_BUSY) || mul_issue;
  assign load_use   = ex_is_load && (ex_dst != '0) &&
                      ((ex_dst == id_src1) || (id_uses_src2 && (ex_dst == id_src2)));

  always_comb begin
    cause = CAUSE_NONE;
    if (dcache_miss)          cause = CAUSE_DCACHE;
    else if (mul_active)      cause = CAUSE_MUL;
    else if (load_use)        cause = CAUSE_LOAD_USE;
    else if (ex_branch_taken) cause = CAUSE_BRANCH;
    else if (icache_miss)     cause = CAUSE_ICACHE;
  end

  // A dcache miss freezes the whole pipe, MUL occupancy included.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    if (!dcache_miss) begin
      if (state_q == ST_RUN) begin
        if (mul_issue) begin
          state_d   = ST_MUL_BUSY;
          mul_cnt_d = MUL_RELOAD;
        end
      end else begin
        mul_cnt_d = mul_cnt_q - MCNT_W'(1);
        if (mul_cnt_q == MCNT_W'(1)) state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // While in reset every register loads a NOP so the pipe drains clean.
  always_comb begin
    en_reg  = '1;
    bubble  = '0;
    wb_kill = 1'b0;
    if (!reset) begin
      bubble  = '1;
      wb_kill = 1'b1;
    end else begin
      case (cause)
        CAUSE_DCACHE: begin
          en_reg  = '0;
          wb_kill = 1'b1;
        end
        CAUSE_MUL: begin
          en_reg[REG_FD] = 1'b0;
          en_reg[REG_DE] = 1'b0;
          bubble[REG_EM] = 1'b1;
        end
        CAUSE_LOAD_USE: begin
          en_reg[REG_FD] = 1'b0;
          bubble[REG_DE] = 1'b1;
        end
        CAUSE_BRANCH: begin
          bubble[REG_FD] = 1'b1;
          bubble[REG_DE] = 1'b1;
        end
        CAUSE_ICACHE: bubble[REG_FD] = 1'b1;
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
    .clk   (clk),
    .reset (reset),
    .inc   (cause == CAUSE_DCACHE),
    .count (stall_d)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_i (
    .clk   (clk),
    .reset (reset),
    .inc   (cause == CAUSE_ICACHE),
    .count (stall_i)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_hz (
    .clk   (clk),
    .reset (reset),
    .inc   ((cause == CAUSE_MUL) || (cause == CAUSE_LOAD_USE)),
    .count (stall_hz)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written MUL/dcache/
// reset sequences, and randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int NUM_STAGES = 5;
  localparam int REG_W      = 5;
  localparam int MUL_LAT    = 5;
  localparam int CNT_W      = 4;
  localparam int SAT        = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             icache_miss, dcache_miss;
  logic [REG_W-1:0] id_src1, id_src2, ex_dst;
  logic             id_uses_src2, ex_is_load, ex_is_mul, ex_branch_taken;
  logic [3:0]       en_reg, bubble;
  logic             wb_kill;
  logic [CNT_W-1:0] stall_d, stall_i, stall_hz;

  int checks = 0;
  int errors = 0;

  // Reference model state: MUL stall cycles still owed after the current one.
  int m_mul_left = 0;
  int m_sd = 0, m_si = 0, m_shz = 0;

  pipeline_hazard_ctrl #(
    .NUM_STAGES(NUM_STAGES), .REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_is_mul(ex_is_mul),
    .ex_branch_taken(ex_branch_taken), .en_reg(en_reg), .bubble(bubble),
    .wb_kill(wb_kill), .stall_d(stall_d), .stall_i(stall_i), .stall_hz(stall_hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       icm, dcm, uses2, ld, br;
    logic [4:0] src1, src2, dst;
    logic [3:0] exp_en, exp_bub;
    logic       exp_kill;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic icm, logic dcm, logic ld, logic [4:0] dst,
                              logic [4:0] s1, logic [4:0] s2, logic u2, logic br,
                              logic [3:0] en, logic [3:0] bub, logic kill);
    vec_t v;
    v.icm = icm; v.dcm = dcm; v.ld = ld; v.dst = dst; v.src1 = s1; v.src2 = s2;
    v.uses2 = u2; v.br = br; v.exp_en = en; v.exp_bub = bub; v.exp_kill = kill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic icm, input logic dcm,
                       input logic ld, input logic [4:0] dst, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u2, input logic mul,
                       input logic br);
    reset = rst; icache_miss = icm; dcache_miss = dcm; ex_is_load = ld;
    ex_dst = dst; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
    ex_is_mul = mul; ex_branch_taken = br;
  endtask

  task automatic idle_in(input logic rst);
    drive(rst, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // cause: 0 none, 1 dcache, 2 mul, 3 load-use, 4 branch, 5 icache, -1 reset
  task automatic model(output logic [3:0] e, output logic [3:0] b,
                       output logic k, output int c);
    bit lu;
    lu = ex_is_load && (ex_dst != 0) &&
         ((ex_dst == id_src1) || (id_uses_src2 && (ex_dst == id_src2)));
    if (!reset)                                begin e = 4'hF; b = 4'hF; k = 1; c = -1; end
    else if (dcache_miss)                      begin e = 4'h0; b = 4'h0; k = 1; c = 1; end
    else if (m_mul_left > 0 || ex_is_mul)      begin e = 4'hC; b = 4'h4; k = 0; c = 2; end
    else if (lu)                               begin e = 4'hE; b = 4'h2; k = 0; c = 3; end
    else if (ex_branch_taken)                  begin e = 4'hF; b = 4'h3; k = 0; c = 4; end
    else if (icache_miss)                      begin e = 4'hF; b = 4'h1; k = 0; c = 5; end
    else                                       begin e = 4'hF; b = 4'h0; k = 0; c = 0; end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e, b; logic k; int c;
    model(e, b, k, c);
    chk({tag, " en_reg"}, 32'(en_reg), 32'(e));
    chk({tag, " bubble"}, 32'(bubble), 32'(b));
    chk({tag, " wb_kill"}, 32'(wb_kill), 32'(k));
    chk({tag, " stall_d"}, 32'(stall_d), 32'(m_sd));
    chk({tag, " stall_i"}, 32'(stall_i), 32'(m_si));
    chk({tag, " stall_hz"}, 32'(stall_hz), 32'(m_shz));
  endtask

  task automatic tick();
    logic [3:0] e, b; logic k; int c;
    model(e, b, k, c);
    @(posedge clk);
    if (c == -1) begin
      m_mul_left = 0; m_sd = 0; m_si = 0; m_shz = 0;
    end else begin
      case (c)
        1: if (m_sd < SAT) m_sd++;
        2: begin
          if (m_shz < SAT) m_shz++;
          if (m_mul_left > 0) m_mul_left--;
          else m_mul_left = MUL_LAT - 1;
        end
        3: if (m_shz < SAT) m_shz++;
        5: if (m_si < SAT) m_si++;
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    int base_i;
    idle_in(0);

    // Reset holds all registers loading NOPs with writeback suppressed.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset en_reg", 32'(en_reg), 32'hF);
      chk("reset bubble", 32'(bubble), 32'hF);
      chk("reset wb_kill", 32'(wb_kill), 32'h1);
      tick();
    end
    idle_in(1);
    @(negedge clk);
    chk("post-reset stall_d", 32'(stall_d), 0);
    chk("post-reset stall_i", 32'(stall_i), 0);
    chk("post-reset stall_hz", 32'(stall_hz), 0);
    chk("idle en_reg", 32'(en_reg), 32'hF);
    chk("idle bubble", 32'(bubble), 32'h0);
    tick();

    // dcache miss for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      @(negedge clk);
      chk("dcache en_reg", 32'(en_reg), 32'h0);
      chk("dcache bubble", 32'(bubble), 32'h0);
      chk("dcache wb_kill", 32'(wb_kill), 32'h1);
      tick();
    end
    idle_in(1);
    @(negedge clk);
    chk("dcache stall_d", 32'(stall_d), 4);
    tick();

    // Single-cycle vector table (no MUL, so state stays RUN).
    //             icm dcm ld dst   s1    s2    u2 br  en     bub    kill
    vecs[0] = mk(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 4'hE, 4'h2, 0);
    vecs[1] = mk(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 4'hF, 4'h0, 0);
    vecs[2] = mk(0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 4'hE, 4'h2, 0);
    vecs[3] = mk(0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 4'hF, 4'h0, 0);
    vecs[4] = mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 4'hF, 4'h3, 0);
    vecs[5] = mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 4'hF, 4'h1, 0);
    vecs[6] = mk(0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 4'hE, 4'h2, 0);
    vecs[7] = mk(1, 1, 1, 5'd4, 5'd4, 5'd0, 0, 1, 4'h0, 4'h0, 1);
    vecs[8] = mk(0, 0, 0, 5'd2, 5'd2, 5'd2, 1, 0, 4'hF, 4'h0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, vecs[i].icm, vecs[i].dcm, vecs[i].ld, vecs[i].dst, vecs[i].src1,
            vecs[i].src2, vecs[i].uses2, 0, vecs[i].br);
      @(negedge clk);
      chk($sformatf("vec%0d en_reg", i), 32'(en_reg), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d bubble", i), 32'(bubble), 32'(vecs[i].exp_bub));
      chk($sformatf("vec%0d wb_kill", i), 32'(wb_kill), 32'(vecs[i].exp_kill));
      chk($sformatf("vec%0d stall_hz", i), 32'(stall_hz), 32'(m_shz));
      chk($sformatf("vec%0d stall_i", i), 32'(stall_i), 32'(m_si));
      tick();
    end

    // icache miss alone for 3 cycles.
    base_i = m_si;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      @(negedge clk);
      chk("icache en_reg", 32'(en_reg), 32'hF);
      chk("icache bubble", 32'(bubble), 32'h1);
      tick();
    end
    idle_in(1);
    @(negedge clk);
    chk("icache stall_i +3", 32'(stall_i), 32'(base_i + 3));
    tick();

    // Plain MUL: five stall cycles then back to running.
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, (i == 0), 0);
      @(negedge clk);
      chk($sformatf("mul c%0d en_reg", i), 32'(en_reg), (i < MUL_LAT) ? 32'hC : 32'hF);
      chk($sformatf("mul c%0d bubble", i), 32'(bubble), (i < MUL_LAT) ? 32'h4 : 32'h0);
      tick();
    end

    // MUL with a 2-cycle dcache miss starting in its third cycle: 7 stall cycles.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, (i == 3 || i == 4), 0, 5'd0, 5'd0, 5'd0, 0, (i == 1), 0);
      @(negedge clk);
      if (i == 3 || i == 4)
        chk($sformatf("mul+dc c%0d en_reg", i), 32'(en_reg), 32'h0);
      else if (i <= 7)
        chk($sformatf("mul+dc c%0d en_reg", i), 32'(en_reg), 32'hC);
      else
        chk($sformatf("mul+dc c%0d en_reg", i), 32'(en_reg), 32'hF);
      check_model($sformatf("mul+dc c%0d", i));
      tick();
    end

    // Reset asserted in the middle of a MUL.
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    @(negedge clk);
    tick();
    idle_in(1);
    @(negedge clk);
    chk("mul busy en_reg", 32'(en_reg), 32'hC);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle_in(0);
      @(negedge clk);
      chk("mid-mul reset en_reg", 32'(en_reg), 32'hF);
      chk("mid-mul reset bubble", 32'(bubble), 32'hF);
      chk("mid-mul reset wb_kill", 32'(wb_kill), 32'h1);
      tick();
    end
    idle_in(1);
    @(negedge clk);
    chk("after reset en_reg", 32'(en_reg), 32'hF);
    chk("after reset bubble", 32'(bubble), 32'h0);
    chk("after reset stall_hz", 32'(stall_hz), 0);
    chk("after reset stall_d", 32'(stall_d), 0);
    tick();

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      @(negedge clk);
      tick();
    end
    idle_in(1);
    @(negedge clk);
    chk("stall_i saturates", 32'(stall_i), 32'(SAT));
    tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
      @(negedge clk);
      check_model($sformatf("rand%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
